// File: rtl/mem_access_stage.sv
// Memory access stage: sits after EX. ALU results go straight to write-back
// one cycle later. A load or store becomes a single req/ack transaction on the
// data bus. The upstream pipeline is held while that transaction is
// outstanding. Misaligned accesses, illegal funct3 values and bus timeouts
// each produce a one-cycle mem_err_o pulse.
//
// state | meaning
// IDLE  | accepting EX results; ALU results and bad mem ops resolve here
// BUS   | bus_req_o high, waiting for bus_ack_i or for the timeout to expire
module mem_access_stage #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic [6:0]  ex_opcode_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic [31:0] ex_rd_data_i,
    input  logic [31:0] ex_store_data_i,
    output logic        mem2cu_hold_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        wb_we_o,
    output logic [4:0]  wb_rd_addr_o,
    output logic [31:0] wb_rd_data_o,
    output logic        mem_err_o
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // The counter only has to reach TIMEOUT_CYC-1, so clog2 of the limit is enough.
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic {
        S_IDLE,
        S_BUS
    } state_t;

    state_t       state;
    logic [CW-1:0] tmo_cnt;
    logic [4:0]   lat_rd;
    logic [2:0]   lat_funct3;
    logic [1:0]   lat_lane;

    logic         is_load;
    logic         is_store;
    logic         is_mem;
    logic         f3_legal;
    logic         aligned;
    logic         mem_go;
    logic         mem_bad;
    logic         tmo_hit;
    logic [3:0]   be_calc;
    logic [31:0]  wdata_calc;
    logic [31:0]  rd_shift;
    logic [31:0]  load_data;

    // Decode the EX result: legality, alignment, byte lanes and store data.
    always_comb begin
        is_load    = (ex_opcode_i == OP_LOAD);
        is_store   = (ex_opcode_i == OP_STORE);
        is_mem     = is_load | is_store;
        f3_legal   = 1'b0;
        aligned    = 1'b1;
        be_calc    = 4'b1111;
        wdata_calc = ex_store_data_i;

        case (ex_funct3_i)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = is_load;
            default:                f3_legal = 1'b0;
        endcase

        case (ex_funct3_i[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << ex_rd_data_i[1:0];
                wdata_calc = {4{ex_store_data_i[7:0]}};
            end
            2'b01: begin
                aligned    = ~ex_rd_data_i[0];
                be_calc    = 4'b0011 << ex_rd_data_i[1:0];
                wdata_calc = {2{ex_store_data_i[15:0]}};
            end
            2'b10: begin
                aligned    = (ex_rd_data_i[1:0] == 2'b00);
                be_calc    = 4'b1111;
                wdata_calc = ex_store_data_i;
            end
            default: begin
                aligned    = 1'b1;
                be_calc    = 4'b1111;
                wdata_calc = ex_store_data_i;
            end
        endcase

        mem_go  = (state == S_IDLE) && ex_valid_i && is_mem && f3_legal && aligned;
        mem_bad = (state == S_IDLE) && ex_valid_i && is_mem && !(f3_legal && aligned);
        tmo_hit = (TIMEOUT_CYC != 0) && (tmo_cnt == TMO_LAST);
    end

    // Pick the addressed lane out of the read word and extend it to 32 bits.
    always_comb begin
        rd_shift  = bus_rdata_i >> {lat_lane, 3'b000};
        load_data = rd_shift;
        case (lat_funct3)
            3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_data = {24'h0, rd_shift[7:0]};
            3'b101:  load_data = {16'h0, rd_shift[15:0]};
            default: load_data = bus_rdata_i;
        endcase
    end

    // The stall has to reach the CU in the same cycle, so it stays combinational.
    always_comb begin
        mem2cu_hold_o = mem_go || ((state == S_BUS) && !bus_ack_i);
    end

    // Two-state FSM plus the one-cycle write-back and error slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            tmo_cnt      <= '0;
            lat_rd       <= '0;
            lat_funct3   <= '0;
            lat_lane     <= '0;
            bus_req_o    <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_addr_o   <= '0;
            bus_wdata_o  <= '0;
            bus_be_o     <= '0;
            wb_we_o      <= 1'b0;
            wb_rd_addr_o <= '0;
            wb_rd_data_o <= '0;
            mem_err_o    <= 1'b0;
        end else begin
            wb_we_o   <= 1'b0;
            mem_err_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_go) begin
                        state       <= S_BUS;
                        tmo_cnt     <= '0;
                        lat_rd      <= ex_rd_addr_i;
                        lat_funct3  <= ex_funct3_i;
                        lat_lane    <= ex_rd_data_i[1:0];
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= is_store;
                        bus_addr_o  <= {ex_rd_data_i[31:2], 2'b00};
                        bus_wdata_o <= wdata_calc;
                        bus_be_o    <= be_calc;
                    end else if (mem_bad) begin
                        mem_err_o <= 1'b1;
                    end else if (ex_valid_i && !is_mem) begin
                        wb_we_o      <= (ex_rd_addr_i != 5'd0);
                        wb_rd_addr_o <= ex_rd_addr_i;
                        wb_rd_data_o <= ex_rd_data_i;
                    end
                end
                S_BUS: begin
                    if (bus_ack_i) begin
                        state     <= S_IDLE;
                        bus_req_o <= 1'b0;
                        if (!bus_we_o) begin
                            wb_we_o      <= (lat_rd != 5'd0);
                            wb_rd_addr_o <= lat_rd;
                            wb_rd_data_o <= load_data;
                        end
                    end else if (tmo_hit) begin
                        state     <= S_IDLE;
                        bus_req_o <= 1'b0;
                        mem_err_o <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    bus_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage, built with a 4-cycle bus timeout.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid_i;
    logic [6:0]  ex_opcode_i;
    logic [2:0]  ex_funct3_i;
    logic [4:0]  ex_rd_addr_i;
    logic [31:0] ex_rd_data_i;
    logic [31:0] ex_store_data_i;
    logic        mem2cu_hold_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        wb_we_o;
    logic [4:0]  wb_rd_addr_o;
    logic [31:0] wb_rd_data_o;
    logic        mem_err_o;

    int checks   = 0;
    int failures = 0;

    int          hold_n, req_n, err_n, wb_n;
    logic        got_bus;
    logic [31:0] cap_addr, cap_wdata, wb_d;
    logic [3:0]  cap_be;
    logic        cap_we;
    logic [4:0]  wb_a;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0010011;

    mem_access_stage #(.TIMEOUT_CYC(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_valid_i      (ex_valid_i),
        .ex_opcode_i     (ex_opcode_i),
        .ex_funct3_i     (ex_funct3_i),
        .ex_rd_addr_i    (ex_rd_addr_i),
        .ex_rd_data_i    (ex_rd_data_i),
        .ex_store_data_i (ex_store_data_i),
        .mem2cu_hold_o   (mem2cu_hold_o),
        .bus_req_o       (bus_req_o),
        .bus_we_o        (bus_we_o),
        .bus_addr_o      (bus_addr_o),
        .bus_wdata_o     (bus_wdata_o),
        .bus_be_o        (bus_be_o),
        .bus_ack_i       (bus_ack_i),
        .bus_rdata_i     (bus_rdata_i),
        .wb_we_o         (wb_we_o),
        .wb_rd_addr_o    (wb_rd_addr_o),
        .wb_rd_data_o    (wb_rd_data_o),
        .mem_err_o       (mem_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        hold_n += int'(mem2cu_hold_o);
        req_n  += int'(bus_req_o);
        err_n  += int'(mem_err_o);
        if (wb_we_o) begin
            wb_n++;
            wb_a = wb_rd_addr_o;
            wb_d = wb_rd_data_o;
        end
        if (bus_req_o && !got_bus) begin
            got_bus   = 1'b1;
            cap_addr  = bus_addr_o;
            cap_wdata = bus_wdata_o;
            cap_be    = bus_be_o;
            cap_we    = bus_we_o;
        end
    endtask

    // Issue one EX result and watch 8 further cycles; ack_at=0 means no ack.
    task automatic run_access(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                              input logic [31:0] ea, input logic [31:0] sd,
                              input int ack_at, input logic [31:0] rdata);
        hold_n = 0; req_n = 0; err_n = 0; wb_n = 0;
        got_bus = 1'b0; cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
        wb_a = '0; wb_d = '0;
        @(negedge clk);
        ex_valid_i = 1'b1; ex_opcode_i = op; ex_funct3_i = f3;
        ex_rd_addr_i = rd; ex_rd_data_i = ea; ex_store_data_i = sd;
        #1 sample();
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            ex_valid_i = 1'b0;
            bus_ack_i  = (i == ack_at);
            bus_rdata_i = (i == ack_at) ? rdata : 32'h0;
            #1 sample();
        end
        bus_ack_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ex_valid_i = 1'b0; ex_opcode_i = '0; ex_funct3_i = '0;
        ex_rd_addr_i = '0; ex_rd_data_i = '0; ex_store_data_i = '0;
        bus_ack_i = 1'b0; bus_rdata_i = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req",   32'(bus_req_o), 32'h0);
        chk("rst_hold",  32'(mem2cu_hold_o), 32'h0);
        chk("rst_wbwe",  32'(wb_we_o), 32'h0);
        chk("rst_err",   32'(mem_err_o), 32'h0);
        chk("rst_addr",  bus_addr_o, 32'h0);
        chk("rst_wbdat", wb_rd_data_o, 32'h0);
        @(negedge clk) rst = 1'b0;

        // ALU pass-through
        @(negedge clk);
        ex_valid_i = 1'b1; ex_opcode_i = OP_ALU; ex_funct3_i = 3'b000;
        ex_rd_addr_i = 5'd5; ex_rd_data_i = 32'h1234;
        #1 chk("alu_hold", 32'(mem2cu_hold_o), 32'h0);
        @(negedge clk);
        ex_valid_i = 1'b0;
        chk("alu_wbwe", 32'(wb_we_o), 32'h1);
        chk("alu_wbrd", 32'(wb_rd_addr_o), 32'd5);
        chk("alu_wbd",  wb_rd_data_o, 32'h1234);
        @(negedge clk);
        chk("alu_pulse", 32'(wb_we_o), 32'h0);
        chk("alu_keep",  32'(wb_rd_addr_o), 32'd5);
        ex_valid_i = 1'b1; ex_rd_addr_i = 5'd0; ex_rd_data_i = 32'h55;
        @(negedge clk);
        ex_valid_i = 1'b0;
        chk("alu_r0_we", 32'(wb_we_o), 32'h0);
        chk("alu_r0_d",  wb_rd_data_o, 32'h55);

        // LB at lane 3, ack in the 4th bus cycle (same cycle as timeout limit)
        run_access(OP_LOAD, 3'b000, 5'd9, 32'h1003, 32'h0, 4, 32'h80FF_FFFF);
        chk("lb_addr", cap_addr, 32'h1000);
        chk("lb_be",   32'(cap_be), 32'h8);
        chk("lb_we",   32'(cap_we), 32'h0);
        chk("lb_hold", 32'(hold_n), 32'd4);
        chk("lb_req",  32'(req_n), 32'd4);
        chk("lb_err",  32'(err_n), 32'd0);
        chk("lb_wbn",  32'(wb_n), 32'd1);
        chk("lb_wba",  32'(wb_a), 32'd9);
        chk("lb_data", wb_d, 32'hFFFF_FF80);

        run_access(OP_LOAD, 3'b100, 5'd9, 32'h1003, 32'h0, 4, 32'h80FF_FFFF);
        chk("lbu_data", wb_d, 32'h0000_0080);
        chk("lbu_wbn",  32'(wb_n), 32'd1);

        // LH upper half, sign extension
        run_access(OP_LOAD, 3'b001, 5'd4, 32'h4002, 32'h0, 1, 32'h8001_0000);
        chk("lh_data", wb_d, 32'hFFFF_8001);
        chk("lh_be",   32'(cap_be), 32'hC);
        chk("lh_hold", 32'(hold_n), 32'd1);

        // LHU lower half, zero extension
        run_access(OP_LOAD, 3'b101, 5'd4, 32'h4000, 32'h0, 2, 32'h1234_9ABC);
        chk("lhu_data", wb_d, 32'h0000_9ABC);

        // SH to upper half
        run_access(OP_STORE, 3'b001, 5'd0, 32'h2002, 32'h0000_ABCD, 2, 32'h0);
        chk("sh_addr",  cap_addr, 32'h2000);
        chk("sh_be",    32'(cap_be), 32'hC);
        chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("sh_we",    32'(cap_we), 32'h1);
        chk("sh_wbn",   32'(wb_n), 32'd0);
        chk("sh_hold",  32'(hold_n), 32'd2);

        // SB to lane 1
        run_access(OP_STORE, 3'b000, 5'd0, 32'h5001, 32'h1234_5678, 1, 32'h0);
        chk("sb_be",    32'(cap_be), 32'h2);
        chk("sb_wdata", cap_wdata, 32'h7878_7878);

        // SW full word, rd ignored for stores
        run_access(OP_STORE, 3'b010, 5'd8, 32'h5004, 32'hCAFE_F00D, 1, 32'h0);
        chk("sw_be",    32'(cap_be), 32'hF);
        chk("sw_wdata", cap_wdata, 32'hCAFE_F00D);
        chk("sw_wbn",   32'(wb_n), 32'd0);

        // LW to x0: bus access but no write-back
        run_access(OP_LOAD, 3'b010, 5'd0, 32'h6000, 32'h0, 1, 32'hDEAD_BEEF);
        chk("lw0_req", 32'(req_n), 32'd1);
        chk("lw0_wbn", 32'(wb_n), 32'd0);

        // Misaligned LW
        run_access(OP_LOAD, 3'b010, 5'd7, 32'h3001, 32'h0, 0, 32'h0);
        chk("mis_req",  32'(req_n), 32'd0);
        chk("mis_hold", 32'(hold_n), 32'd0);
        chk("mis_err",  32'(err_n), 32'd1);
        chk("mis_wbn",  32'(wb_n), 32'd0);

        // Misaligned LH
        run_access(OP_LOAD, 3'b001, 5'd7, 32'h3003, 32'h0, 0, 32'h0);
        chk("mish_err", 32'(err_n), 32'd1);
        chk("mish_req", 32'(req_n), 32'd0);

        // Illegal load funct3
        run_access(OP_LOAD, 3'b011, 5'd7, 32'h3000, 32'h0, 0, 32'h0);
        chk("f3_req",  32'(req_n), 32'd0);
        chk("f3_hold", 32'(hold_n), 32'd0);
        chk("f3_err",  32'(err_n), 32'd1);

        // Illegal store funct3 (100 is only a load size)
        run_access(OP_STORE, 3'b100, 5'd0, 32'h3000, 32'h0, 0, 32'h0);
        chk("sf3_err", 32'(err_n), 32'd1);
        chk("sf3_req", 32'(req_n), 32'd0);

        // Timeout: no ack ever
        run_access(OP_LOAD, 3'b010, 5'd6, 32'h7000, 32'h0, 0, 32'h0);
        chk("tmo_req",  32'(req_n), 32'd4);
        chk("tmo_hold", 32'(hold_n), 32'd5);
        chk("tmo_err",  32'(err_n), 32'd1);
        chk("tmo_wbn",  32'(wb_n), 32'd0);
        chk("tmo_idle", 32'(bus_req_o), 32'h0);

        // Ack while idle is ignored
        @(negedge clk);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_ack_i = 1'b0;
        chk("iack_we",  32'(wb_we_o), 32'h0);
        chk("iack_err", 32'(mem_err_o), 32'h0);
        chk("iack_req", 32'(bus_req_o), 32'h0);

        // Reset in the middle of a bus transaction
        @(negedge clk);
        ex_valid_i = 1'b1; ex_opcode_i = OP_LOAD; ex_funct3_i = 3'b010;
        ex_rd_addr_i = 5'd3; ex_rd_data_i = 32'h7000;
        @(negedge clk);
        ex_valid_i = 1'b0;
        @(negedge clk);
        #1 chk("mid_req", 32'(bus_req_o), 32'h1);
        rst = 1'b1;
        #1;
        chk("mrst_req",  32'(bus_req_o), 32'h0);
        chk("mrst_hold", 32'(mem2cu_hold_o), 32'h0);
        chk("mrst_wbwe", 32'(wb_we_o), 32'h0);
        @(negedge clk) rst = 1'b0;

        run_access(OP_LOAD, 3'b010, 5'd3, 32'h7000, 32'h0, 2, 32'h1122_3344);
        chk("post_req",  32'(req_n), 32'd2);
        chk("post_wba",  32'(wb_a), 32'd3);
        chk("post_data", wb_d, 32'h1122_3344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
